// File: rtl/mouse_pkg.sv
// mouse_pkg: FSM states, byte-0 bit positions and delta saturation shared by the mouse decoder.
package mouse_pkg;
    typedef enum logic [2:0] {B0, B1, B2, B3, DONE} state_t;
    localparam int ALWAYS1 = 3;
    localparam int XS = 4;
    localparam int YS = 5;
    localparam int XO = 6;
    localparam int YO = 7;
    function automatic logic [8:0] sat_delta(input logic s, input logic o, input logic [7:0] v);
        return o ? (s ? 9'h100 : 9'h0ff) : {s, v};
    endfunction
endpackage

// File: rtl/mouse_axis_clamp.sv
// mouse_axis_clamp: scales a packet delta, optionally accelerates it, and clamps the moved position.
// Acceleration is compiled in when MOUSE_ACCEL_EN is defined.
module mouse_axis_clamp #(
    parameter int W            = 10,
    parameter int MAX          = 639,
    parameter int SHIFT        = 0,
    parameter int ACCEL_THRESH = 8
) (
    input  logic [W-1:0]      pos,
    input  logic signed [8:0] delta,
    output logic [W-1:0]      npos
);
    localparam int S = W + 2;
    logic signed [8:0]   step;
    logic signed [S-1:0] st, adj, sum;
    if (ACCEL_THRESH < 0) begin : g_bad_thresh
        $error("ACCEL_THRESH must be non-negative");
    end
    always_comb begin
        step = delta >>> SHIFT;
        st = S'(step);
`ifdef MOUSE_ACCEL_EN
        adj = ((st < 0 ? -st : st) > S'(ACCEL_THRESH)) ? st <<< 1 : st;
`else
        adj = st;
`endif
        sum = $signed({2'b00, pos}) + adj;
        npos = sum < 0 ? '0 : (sum > S'(MAX) ? W'(MAX) : W'(sum));
    end
endmodule

// File: rtl/mouse_packet_decoder.sv
// mouse_packet_decoder: frames PS/2 mouse bytes into 3/4-byte packets and tracks a clamped cursor.
// Define MOUSE_ACCEL_EN to double cursor steps larger than ACCEL_THRESH.
module mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter int PKT_BYTES    = 3,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int INIT_X       = 320,
    parameter int INIT_Y       = 240,
    parameter int SHIFT        = 0,
    parameter int TIMEOUT_CYC  = 2_000_000,
    parameter int ACCEL_THRESH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mouseReady,
    input  logic [7:0]     mouseData,
    output logic           pkt_valid,
    output logic [8:0]     dx,
    output logic [8:0]     dy,
    output logic [3:0]     dz,
    output logic [2:0]     buttons,
    output logic [2:0]     btn_press,
    output logic [X_W-1:0] cursor_x,
    output logic [Y_W-1:0] cursor_y,
    output logic [7:0]     sync_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    state_t         state, nstate;
    logic [1:0]     smp;
    logic [TW-1:0]  tcnt;
    logic           acc, at_hdr, in_pkt, hdr_ok, bad_hdr, tout, fin;
    logic [2:0]     btn_l;
    logic           xs_l, ys_l, xo_l, yo_l;
    logic [7:0]     x_l, y_l, y_n;
    logic [8:0]     ry;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;

    if (PKT_BYTES != 3 && PKT_BYTES != 4) begin : g_bad_pkt
        $error("PKT_BYTES must be 3 or 4");
    end

    assign acc       = smp == 2'b01;
    assign at_hdr    = state == B0 || state == DONE;
    assign in_pkt    = state inside {B1, B2, B3};
    assign hdr_ok    = acc && at_hdr && mouseData[ALWAYS1];
    assign bad_hdr   = acc && at_hdr && !mouseData[ALWAYS1];
    assign tout      = in_pkt && !acc && tcnt == TW'(TIMEOUT_CYC - 1);
    assign fin       = acc && (state == B3 || (state == B2 && PKT_BYTES == 3));
    assign pkt_valid = state == DONE;
    // the last Y byte is still on mouseData when a 3-byte packet completes
    assign y_n       = state == B2 ? mouseData : y_l;
    assign ry        = sat_delta(ys_l, yo_l, y_n);

    always_comb begin
        nstate = state;
        case (state)
            B0, DONE: nstate = hdr_ok ? B1 : B0;
            B1:       nstate = acc ? B2 : (tout ? B0 : B1);
            B2:       nstate = acc ? (PKT_BYTES == 4 ? B3 : DONE) : (tout ? B0 : B2);
            B3:       nstate = acc ? DONE : (tout ? B0 : B3);
            default:  nstate = B0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= B0;
        else     state <= nstate;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp       <= '0;
            tcnt      <= '0;
            sync_err  <= '0;
            {yo_l, xo_l, ys_l, xs_l, btn_l} <= '0;
            x_l       <= '0;
            y_l       <= '0;
            dx        <= '0;
            dy        <= '0;
            dz        <= '0;
            buttons   <= '0;
            btn_press <= '0;
            cursor_x  <= X_W'(INIT_X);
            cursor_y  <= Y_W'(INIT_Y);
        end else begin
            smp  <= {smp[0], mouseReady};
            tcnt <= (acc || !in_pkt) ? '0 : tcnt + 1'b1;
            if ((bad_hdr || tout) && sync_err != 8'hff) sync_err <= sync_err + 1'b1;
            if (hdr_ok) {yo_l, xo_l, ys_l, xs_l, btn_l} <= {mouseData[YO], mouseData[XO], mouseData[YS], mouseData[XS], mouseData[2:0]};
            if (acc && state == B1) x_l <= mouseData;
            if (acc && state == B2) y_l <= mouseData;
            btn_press <= fin ? btn_l & ~buttons : '0;
            if (fin) begin
                buttons <= btn_l;
                dx      <= sat_delta(xs_l, xo_l, x_l);
                dy      <= ry == 9'h100 ? 9'h0ff : -ry;
                dz      <= PKT_BYTES == 4 ? mouseData[3:0] : '0;
            end
            if (pkt_valid) begin
                cursor_x <= nx;
                cursor_y <= ny;
            end
        end
    end

    mouse_axis_clamp #(.W(X_W), .MAX(SCREEN_W - 1), .SHIFT(SHIFT), .ACCEL_THRESH(ACCEL_THRESH)) u_x (
        .pos(cursor_x), .delta(dx), .npos(nx)
    );
    mouse_axis_clamp #(.W(Y_W), .MAX(SCREEN_H - 1), .SHIFT(SHIFT), .ACCEL_THRESH(ACCEL_THRESH)) u_y (
        .pos(cursor_y), .delta(dy), .npos(ny)
    );
endmodule

// File: tb/tb_mouse_packet_decoder.sv
// tb_mouse_packet_decoder: a 3-byte (SHIFT 0) and a 4-byte (SHIFT 1) decoder checked against a packet-level model.
module tb_mouse_packet_decoder;
    localparam int TO = 40;
    localparam int TH = 8;

    typedef struct {
        int at, dx, dy, dz, btn, prs, err, cx, cy;
    } exp_t;

    logic       clk = 0;
    logic       rst = 1;
    logic       rdy [2];
    logic [7:0] dat [2];
    logic       pv [2];
    logic [8:0] dx [2];
    logic [8:0] dy [2];
    logic [3:0] dz [2];
    logic [2:0] btn [2];
    logic [2:0] prs [2];
    logic [9:0] cx [2];
    logic [8:0] cy [2];
    logic [7:0] serr [2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int         n [2], lastk [2], merr [2], mcx [2], mcy [2], pbtn [2], wr [2];
    logic [7:0] pk [2][4];
    exp_t       eq [2][64];
    int         rd [2], ecx [2], ecy [2];
    bit         pend [2];
    exp_t       pe [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mouse_packet_decoder #(.PKT_BYTES(3), .SHIFT(0), .TIMEOUT_CYC(TO), .ACCEL_THRESH(TH)) dut0 (
        .clk(clk), .rst(rst), .mouseReady(rdy[0]), .mouseData(dat[0]), .pkt_valid(pv[0]),
        .dx(dx[0]), .dy(dy[0]), .dz(dz[0]), .buttons(btn[0]), .btn_press(prs[0]),
        .cursor_x(cx[0]), .cursor_y(cy[0]), .sync_err(serr[0])
    );
    mouse_packet_decoder #(.PKT_BYTES(4), .SHIFT(1), .TIMEOUT_CYC(TO), .ACCEL_THRESH(TH)) dut1 (
        .clk(clk), .rst(rst), .mouseReady(rdy[1]), .mouseData(dat[1]), .pkt_valid(pv[1]),
        .dx(dx[1]), .dy(dy[1]), .dz(dz[1]), .buttons(btn[1]), .btn_press(prs[1]),
        .cursor_x(cx[1]), .cursor_y(cy[1]), .sync_err(serr[1])
    );

    task automatic chk(input int i, input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)", i, nm, act, exp, cyc);
        end
    endtask

    function automatic int move(input int p, input int d, input int s, input int mx);
        int st = d >= 0 ? d / (1 << s) : -((-d + (1 << s) - 1) / (1 << s));
`ifdef MOUSE_ACCEL_EN
        if ((st < 0 ? -st : st) > TH) st = st * 2;
`endif
        p += st;
        return p < 0 ? 0 : (p > mx ? mx : p);
    endfunction

    function automatic int sval(input logic s, input logic o, input logic [7:0] v);
        return o ? (s ? -256 : 255) : int'(v) - (s ? 256 : 0);
    endfunction

    task automatic bump(input int i);
        if (merr[i] < 255) merr[i]++;
    endtask

    task automatic push(input int i, input int k);
        exp_t       e;
        logic [7:0] h = pk[i][0];
        int         ry = sval(h[5], h[7], pk[i][2]);
        int         z = int'(pk[i][3]) % 16;
        e.at  = k + 2;
        e.dx  = sval(h[4], h[6], pk[i][1]);
        e.dy  = ry == -256 ? 255 : -ry;
        e.dz  = i == 1 ? (z >= 8 ? z - 16 : z) : 0;
        e.btn = int'(h[2:0]);
        e.prs = e.btn & ~pbtn[i];
        pbtn[i] = e.btn;
        e.err = merr[i];
        mcx[i] = move(mcx[i], e.dx, i, 639);
        mcy[i] = move(mcy[i], e.dy, i, 479);
        e.cx  = mcx[i];
        e.cy  = mcy[i];
        eq[i][wr[i] % 64] = e;
        wr[i]++;
    endtask

    task automatic model_byte(input int i, input logic [7:0] b, input int k);
        if (n[i] > 0 && k - lastk[i] > TO) begin
            n[i] = 0;
            bump(i);
        end
        lastk[i] = k;
        if (n[i] == 0 && !b[3]) bump(i);
        else begin
            pk[i][n[i]] = b;
            n[i]++;
            if (n[i] == 3 + i) begin
                push(i, k);
                n[i] = 0;
            end
        end
    endtask

    task automatic compare_cycle();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rd[i] = 0;
                pend[i] = 0;
                ecx[i] = 320;
                ecy[i] = 240;
            end else begin
                if (pend[i]) begin
                    ecx[i] = pe[i].cx;
                    ecy[i] = pe[i].cy;
                    pend[i] = 0;
                end
                chk(i, "cursor_x", int'(cx[i]), ecx[i]);
                chk(i, "cursor_y", int'(cy[i]), ecy[i]);
                if (pv[i]) begin
                    chk(i, "pkt_expected", int'(rd[i] < wr[i]), 1);
                    if (rd[i] < wr[i]) begin
                        e = eq[i][rd[i] % 64];
                        rd[i]++;
                        chk(i, "pkt_cycle", cyc, e.at);
                        chk(i, "dx", int'($signed(dx[i])), e.dx);
                        chk(i, "dy", int'($signed(dy[i])), e.dy);
                        chk(i, "dz", int'($signed(dz[i])), e.dz);
                        chk(i, "buttons", int'(btn[i]), e.btn);
                        chk(i, "btn_press", int'(prs[i]), e.prs);
                        chk(i, "sync_err", int'(serr[i]), e.err);
                        pe[i] = e;
                        pend[i] = 1;
                    end
                end else begin
                    chk(i, "btn_press_idle", int'(prs[i]), 0);
                    if (rd[i] < wr[i]) chk(i, "pkt_missing", int'(cyc > eq[i][rd[i] % 64].at), 0);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            n[i] = 0; lastk[i] = 0; merr[i] = 0; pbtn[i] = 0; wr[i] = 0;
            mcx[i] = 320; mcy[i] = 240;
        end
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic send(input int i, input logic [7:0] b, input int low);
        dat[i] = b;
        rdy[i] = 1;
        model_byte(i, b, cyc);
        @(negedge clk);
        rdy[i] = 0;
        repeat (low) @(negedge clk);
    endtask

    task automatic pkt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(0, a, 2);
        send(0, b, 2);
        send(0, c, 2);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        int gap;
        rdy = '{1'b0, 1'b0};
        dat = '{8'h00, 8'h00};
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(i, "reset_pkt_valid", int'(pv[i]), 0);
            chk(i, "reset_dx", int'(dx[i]), 0);
            chk(i, "reset_cursor_x", int'(cx[i]), 320);
            chk(i, "reset_cursor_y", int'(cy[i]), 240);
            chk(i, "reset_sync_err", int'(serr[i]), 0);
        end
        pkt3(8'h29, 8'h05, 8'hfb);
        chk(0, "lit_dx", int'($signed(dx[0])), 5);
        chk(0, "lit_dy", int'($signed(dy[0])), 5);
        chk(0, "lit_buttons", int'(btn[0]), 1);
        chk(0, "lit_cursor_x", int'(cx[0]), 325);
        chk(0, "lit_cursor_y", int'(cy[0]), 245);
        send(0, 8'h00, 2);
        pkt3(8'h08, 8'h00, 8'h00);
        chk(0, "lit_discard_err", int'(serr[0]), 1);
        chk(0, "lit_zero_dx", int'(dx[0]), 0);
        chk(0, "lit_zero_buttons", int'(btn[0]), 0);
        send(0, 8'h08, 2);
        send(0, 8'h01, 2);
        repeat (3 * TO) @(negedge clk);
        chk(0, "lit_timeout_err", int'(serr[0]), 2);
        pkt3(8'h08, 8'h03, 8'h00);
        chk(0, "lit_after_timeout_dx", int'($signed(dx[0])), 3);
        chk(0, "lit_after_timeout_x", int'(cx[0]), 328);
        pkt3(8'h48, 8'h00, 8'h00);
        chk(0, "lit_xovf_dx", int'($signed(dx[0])), 255);
        for (int j = 0; j < 6; j++) pkt3(8'h18, 8'h80, 8'h00);
        chk(0, "lit_neg_dx", int'($signed(dx[0])), -128);
        chk(0, "lit_clamp_x0", int'(cx[0]), 0);
        pkt3(8'h28, 8'h00, 8'h00);
        chk(0, "lit_yneg256_dy", int'($signed(dy[0])), 255);
        chk(0, "lit_clamp_ymax", int'(cy[0]), 479);
        send(0, 8'h08, 2);
        send(0, 8'h05, 2);
        do_reset();
        repeat (6) @(negedge clk);
        chk(0, "lit_midrst_x", int'(cx[0]), 320);
        chk(0, "lit_midrst_y", int'(cy[0]), 240);
        chk(0, "lit_midrst_err", int'(serr[0]), 0);
        pkt3(8'h08, 8'h0a, 8'h00);
`ifdef MOUSE_ACCEL_EN
        chk(0, "lit_accel_x", int'(cx[0]), 340);
`else
        chk(0, "lit_noaccel_x", int'(cx[0]), 330);
`endif
        send(1, 8'h08, 2);
        send(1, 8'h00, 2);
        send(1, 8'h00, 2);
        send(1, 8'h0f, 2);
        repeat (4) @(negedge clk);
        chk(1, "lit_dz", int'($signed(dz[1])), -1);
        chk(1, "lit_wheel_x", int'(cx[1]), 320);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 200; j++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 3) != 0) b[3] = 1'b1;
                gap = ($urandom_range(0, 39) == 0) ? 2 * TO + int'($urandom_range(0, 20)) : int'($urandom_range(1, 8));
                send(i, b, gap);
            end
            repeat (3 * TO) @(negedge clk);
            if (n[i] > 0) begin
                n[i] = 0;
                bump(i);
            end
            chk(i, "rand_sync_err", int'(serr[i]), merr[i]);
            chk(i, "rand_drained", rd[i], wr[i]);
        end
        for (int j = 0; j < 300; j++) send(0, 8'h00, 1);
        repeat (4) @(negedge clk);
        chk(0, "sat_sync_err", int'(serr[0]), 255);
        chk(0, "sat_model", int'(serr[0]), merr[0]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
